// File: rtl/cache_pkg.sv
// Shared definitions for the cache data and tag arrays.
//   state_e      : array controller states (zeroing sweep, normal operation)
//   way_w_f      : width of a way index for a given number of ways (at least 1)
//   byte_par_f   : even-parity bit for one byte
//   DefaultDataW : default word width shared with the tag array
//   DefaultAddrW : default set-index width shared with the tag array
package cache_pkg;

  localparam int unsigned DefaultDataW = 32;
  localparam int unsigned DefaultAddrW = 6;

  typedef enum logic [0:0] {
    StInit,
    StRun
  } state_e;

  function automatic int unsigned way_w_f(input int unsigned ways);
    return (ways <= 1) ? 1 : $clog2(ways);
  endfunction

  // Stored bit makes the 9-bit group even.
  function automatic logic byte_par_f(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/cache_data_bank.sv
// One way of the cache data array: 2**ADDR_W x DATA_W storage with byte-masked
// write and a write-first combinational read of the addressed word.
// Optional per-byte parity storage under macro CACHE_DATA_ARRAY_PARITY_EN.
// Ports:
//   clk       : clock, rising edge
//   we_i      : write enable for this way
//   addr_i    : word index (read and write)
//   wmask_i   : byte write enables
//   wdata_i   : write data
//   rdata_o   : addressed word; merged new word when written in the same cycle
//   par_err_o : (parity build only) any byte of rdata_o fails parity
module cache_data_bank
  import cache_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned ADDR_W = DefaultAddrW
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [DATA_W/8-1:0]   wmask_i,
  input  logic [DATA_W-1:0]     wdata_i,
`ifdef CACHE_DATA_ARRAY_PARITY_EN
  output logic                  par_err_o,
`endif
  output logic [DATA_W-1:0]     rdata_o
);

  localparam int unsigned NumBytes = DATA_W / 8;
  localparam int unsigned Depth    = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [Depth];
  logic [DATA_W-1:0] merged;

  always_comb begin
    merged = mem_q[addr_i];
    for (int b = 0; b < NumBytes; b++) begin
      if (wmask_i[b]) merged[8*b +: 8] = wdata_i[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= merged;
  end

  assign rdata_o = we_i ? merged : mem_q[addr_i];

`ifdef CACHE_DATA_ARRAY_PARITY_EN
  logic [NumBytes-1:0] par_q [Depth];
  logic [NumBytes-1:0] merged_par;
  logic [NumBytes-1:0] rpar;

  // Parity is regenerated only for written bytes; untouched bytes keep theirs
  // so a corrupted stored byte stays detectable.
  always_comb begin
    merged_par = par_q[addr_i];
    for (int b = 0; b < NumBytes; b++) begin
      if (wmask_i[b]) merged_par[b] = byte_par_f(wdata_i[8*b +: 8]);
    end
  end

  always_ff @(posedge clk) begin
    if (we_i) par_q[addr_i] <= merged_par;
  end

  assign rpar = we_i ? merged_par : par_q[addr_i];

  always_comb begin
    par_err_o = 1'b0;
    for (int b = 0; b < NumBytes; b++) begin
      if (byte_par_f(rdata_o[8*b +: 8]) != rpar[b]) par_err_o = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/cache_data_array.sv
// Multi-way cache data array (I- and D-cache). Reads all ways of one set with
// one-cycle registered latency; byte-masked, way-selected writes; read output
// holds when rd_en_i is low; zeroing sweep of every set after reset.
// Optional per-byte parity: define CACHE_DATA_ARRAY_PARITY_EN.
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset (restarts the sweep)
//   ready_o   : accesses accepted (sweep done)
//   rd_en_i   : read all ways of set addr_i
//   wr_en_i   : write way way_i of set addr_i
//   addr_i    : set index
//   way_i     : write target way; values >= WAYS drop the write
//   wmask_i   : byte write enables
//   data_i    : write data
//   data_o    : registered read data, way w at [w*DATA_W +: DATA_W]
//   par_err_o : per-way parity error, registered with data_o (0 without parity)
module cache_data_array
  import cache_pkg::*;
#(
  parameter int unsigned  DATA_W = DefaultDataW,
  parameter int unsigned  ADDR_W = DefaultAddrW,
  parameter int unsigned  WAYS   = 2,
  localparam int unsigned WAY_W  = way_w_f(WAYS)
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   ready_o,
  input  logic                   rd_en_i,
  input  logic                   wr_en_i,
  input  logic [ADDR_W-1:0]      addr_i,
  input  logic [WAY_W-1:0]       way_i,
  input  logic [DATA_W/8-1:0]    wmask_i,
  input  logic [DATA_W-1:0]      data_i,
  output logic [WAYS*DATA_W-1:0] data_o,
  output logic [WAYS-1:0]        par_err_o
);

  localparam int unsigned NumBytes = DATA_W / 8;
  localparam int unsigned Depth    = 1 << ADDR_W;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                ready_q;
  logic [WAYS*DATA_W-1:0] data_q, data_d;
  logic                rd_take;

  logic [WAYS-1:0]        bank_we;
  logic [ADDR_W-1:0]      bank_addr;
  logic [NumBytes-1:0]    bank_mask;
  logic [DATA_W-1:0]      bank_wdata;
  logic [WAYS*DATA_W-1:0] bank_rdata;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bank_we    = '0;
    bank_addr  = addr_i;
    bank_mask  = wmask_i;
    bank_wdata = data_i;
    rd_take    = 1'b0;
    case (state_q)
      StInit: begin
        // Zero every way of one set per cycle; accesses are ignored.
        bank_we    = '1;
        bank_addr  = cnt_q;
        bank_mask  = '1;
        bank_wdata = '0;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(Depth - 1)) state_d = StRun;
      end
      StRun: begin
        for (int w = 0; w < WAYS; w++) begin
          bank_we[w] = wr_en_i && (way_i == WAY_W'(w));
        end
        rd_take = rd_en_i;
      end
      default: state_d = StInit;
    endcase
    data_d = rd_take ? bank_rdata : data_q;
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
`ifdef CACHE_DATA_ARRAY_PARITY_EN
    logic bank_perr;
`endif
    cache_data_bank #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_bank (
      .clk       (clk),
      .we_i      (bank_we[w]),
      .addr_i    (bank_addr),
      .wmask_i   (bank_mask),
      .wdata_i   (bank_wdata),
`ifdef CACHE_DATA_ARRAY_PARITY_EN
      .par_err_o (bank_perr),
`endif
      .rdata_o   (bank_rdata[w*DATA_W +: DATA_W])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StInit;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == StRun);
      data_q  <= data_d;
    end
  end

  assign ready_o = ready_q;
  assign data_o  = data_q;

`ifdef CACHE_DATA_ARRAY_PARITY_EN
  logic [WAYS-1:0] perr_q, perr_now;

  for (genvar w = 0; w < WAYS; w++) begin : g_perr
    assign perr_now[w] = g_way[w].bank_perr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perr_q <= '0;
    end else if (rd_take) begin
      perr_q <= perr_now;
    end
  end

  assign par_err_o = perr_q;
`else
  assign par_err_o = '0;
`endif

endmodule

// File: tb/tb_cache_data_array.sv
module tb_cache_data_array;
  localparam int DW = 32;
  localparam int AW = 6;
  localparam int NW = 2;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ready_o;
  logic          rd_en_i = 1'b0;
  logic          wr_en_i = 1'b0;
  logic [AW-1:0] addr_i = '0;
  logic [0:0]    way_i = '0;
  logic [3:0]    wmask_i = '0;
  logic [DW-1:0] data_i = '0;
  logic [NW*DW-1:0] data_o;
  logic [NW-1:0] par_err_o;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference contents and the value data_o should currently show.
  logic [DW-1:0]    model [NW][DEPTH];
  logic [NW*DW-1:0] exp_out;
  logic [NW-1:0]    exp_par;

  cache_data_array #(.DATA_W(DW), .ADDR_W(AW), .WAYS(NW)) dut (
    .clk       (clk),
    .rst       (rst),
    .ready_o   (ready_o),
    .rd_en_i   (rd_en_i),
    .wr_en_i   (wr_en_i),
    .addr_i    (addr_i),
    .way_i     (way_i),
    .wmask_i   (wmask_i),
    .data_i    (data_i),
    .data_o    (data_o),
    .par_err_o (par_err_o)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_en_i = 1'b0; wr_en_i = 1'b0; wmask_i = '0; data_i = '0;
  endtask

  task automatic model_clear();
    for (int w = 0; w < NW; w++)
      for (int a = 0; a < DEPTH; a++) model[w][a] = '0;
    exp_out = '0;
    exp_par = '0;
  endtask

  // One access applied to the model: write merges bytes, read sees the result.
  task automatic access(input bit rd, input bit wr, input int a, input int w,
                        input logic [3:0] m, input logic [DW-1:0] d);
    rd_en_i = rd; wr_en_i = wr; addr_i = a[AW-1:0]; way_i = w[0:0];
    wmask_i = m; data_i = d;
    if (wr && w < NW)
      for (int b = 0; b < 4; b++)
        if (m[b]) model[w][a][8*b +: 8] = d[8*b +: 8];
    if (rd) begin
      exp_out = {model[1][a], model[0][a]};
      exp_par = '0;
    end
    cycle();
    idle();
  endtask

  // Returns the number of cycles until ready_o rises, or -1 past the bound.
  task automatic wait_ready(output int n);
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      cycle();
      if (ready_o) begin n = i; break; end
    end
  endtask

  task automatic test_reset();
    int n;
    idle();
    rst = 1'b1;
    repeat (3) cycle();
    n_cmp++;
    if (ready_o !== 1'b0 || data_o !== '0 || par_err_o !== '0) begin
      n_bad++;
      $display("FAIL reset_state: ready=%b data=%h par=%b, required 0/0/0",
               ready_o, data_o, par_err_o);
    end
    rst = 1'b0;
    wait_ready(n);
    n_cmp++;
    if (n != DEPTH) begin
      n_bad++;
      $display("FAIL sweep_length: ready after %0d cycles, required %0d", n, DEPTH);
    end
    model_clear();
    access(1, 0, 5, 0, 4'h0, '0);
    n_cmp++;
    if (data_o !== '0) begin
      n_bad++;
      $display("FAIL read_after_sweep: data=%h, required 0", data_o);
    end
  endtask

  task automatic test_masked_write();
    access(0, 1, 3, 1, 4'b1111, 32'hAABBCCDD);
    access(0, 1, 3, 1, 4'b0101, 32'h11223344);
    access(1, 0, 3, 0, 4'h0, '0);
    n_cmp++;
    if (data_o !== {32'hAA22CC44, 32'h0}) begin
      n_bad++;
      $display("FAIL masked_write: data=%h, required %h", data_o, {32'hAA22CC44, 32'h0});
    end
  endtask

  task automatic test_collision();
    access(1, 1, 7, 0, 4'b1111, 32'hDEADBEEF);
    n_cmp++;
    if (data_o[31:0] !== 32'hDEADBEEF || data_o !== exp_out) begin
      n_bad++;
      $display("FAIL write_first: data=%h, required %h", data_o, exp_out);
    end
  endtask

  task automatic test_hold();
    logic [NW*DW-1:0] held;
    held = exp_out;
    for (int i = 0; i < 5; i++) begin
      access(0, 1, 7, i % 2, 4'b1111, $urandom);
      n_cmp++;
      if (data_o !== held) begin
        n_bad++;
        $display("FAIL hold_%0d: data=%h, required %h", i, data_o, held);
      end
    end
    access(1, 0, 7, 0, 4'h0, '0);
    n_cmp++;
    if (data_o !== exp_out) begin
      n_bad++;
      $display("FAIL hold_writes_landed: data=%h, required %h", data_o, exp_out);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      access($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 15),
             $urandom_range(0, 1), 4'($urandom), $urandom);
      n_cmp++;
      if (data_o !== exp_out || par_err_o !== exp_par) begin
        n_bad++;
        $display("FAIL random_%0d: data=%h par=%b, required %h %b",
                 i, data_o, par_err_o, exp_out, exp_par);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    bit leak;
    idle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (30) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    n = -1;
    leak = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      // Accesses while not ready must be ignored; set 2 is already swept by now.
      if (i == 40) begin
        rd_en_i = 1'b1; wr_en_i = 1'b1; addr_i = 2; way_i = 1;
        wmask_i = 4'hF; data_i = 32'hFFFF_FFFF;
      end
      cycle();
      idle();
      if (!ready_o && data_o !== '0) leak = 1'b1;
      if (ready_o) begin n = i; break; end
    end
    n_cmp++;
    if (n != DEPTH) begin
      n_bad++;
      $display("FAIL mid_sweep_length: ready after %0d cycles, required %0d", n, DEPTH);
    end
    n_cmp++;
    if (leak) begin
      n_bad++;
      $display("FAIL init_data_hold: data_o nonzero during sweep, required 0");
    end
    model_clear();
    access(1, 0, 2, 0, 4'h0, '0);
    n_cmp++;
    if (data_o !== '0) begin
      n_bad++;
      $display("FAIL init_write_ignored: data=%h, required 0", data_o);
    end
  endtask

`ifdef CACHE_DATA_ARRAY_PARITY_EN
  task automatic test_parity();
    access(0, 1, 9, 0, 4'hF, $urandom);
    access(0, 1, 9, 1, 4'hF, $urandom);
    dut.g_way[0].u_bank.mem_q[9][5] = ~dut.g_way[0].u_bank.mem_q[9][5];
    model[0][9][5] = ~model[0][9][5];
    access(1, 0, 9, 0, 4'h0, '0);
    n_cmp++;
    if (par_err_o !== 2'b01) begin
      n_bad++;
      $display("FAIL parity_flip: par=%b, required 01", par_err_o);
    end
    access(1, 0, 10, 0, 4'h0, '0);
    n_cmp++;
    if (par_err_o !== 2'b00) begin
      n_bad++;
      $display("FAIL parity_clean: par=%b, required 00", par_err_o);
    end
    // Repair the corrupted word so later reads are clean.
    access(0, 1, 9, 0, 4'hF, model[0][9]);
  endtask
`endif

  initial begin
    model_clear();
    test_reset();
    test_masked_write();
    test_collision();
    test_hold();
`ifdef CACHE_DATA_ARRAY_PARITY_EN
    test_parity();
`endif
    test_random();
    test_reset_mid_sweep();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cache_data_array.md
Name: cache_data_array

Overview:
- Parametrised, multi-way successor to the single-port instruction-cache data RAM.
- Serves as the data store for both I- and D-cache.
- Reads all ways of one set in parallel, with one-cycle registered latency, so the hit-way mux can sit downstream.
- Adds byte-masked, way-selected writes, read-enable output hold, and a post-reset zeroing sweep.

Parameters:
- DATA_W, 32, bits per word; must be a multiple of 8.
- ADDR_W, 6, set-index width; DEPTH = 2**ADDR_W.
- WAYS, 2, number of ways (1..8).
- WAY_W, derived as max(1, clog2(WAYS)); not user-set.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- ready_o  out  1  high when the array accepts accesses (init sweep done)
- rd_en_i  in  1  read request for set addr_i
- wr_en_i  in  1  write request
- addr_i  in  ADDR_W  set index, shared by read and write
- way_i  in  WAY_W  target way for the write
- wmask_i  in  DATA_W/8  byte write enables
- data_i  in  DATA_W  write data
- data_o  out  WAYS*DATA_W  registered read data; way w at bits [w*DATA_W +: DATA_W]
- par_err_o  out  WAYS  parity error per way (feature only; tied 0 otherwise)

Behaviour:
- Clock and reset: one clock, clk; rst is synchronous and active-high.
- Reset values: on rst, state <= INIT, sweep counter <= 0, ready_o <= 0, data_o <= 0, par_err_o <= 0.
- FSM states:
  - INIT: each cycle, write 0 to all ways at index cnt, then cnt++.
  - After index DEPTH-1 is written: go to RUN and set ready_o = 1 on the next cycle.
  - Sweep length is exactly DEPTH cycles after rst deasserts.
- While INIT: rd_en_i and wr_en_i are ignored; data_o holds 0.
- RUN, write: when wr_en_i is high, bytes of ram[way_i][addr_i] with wmask_i[b]=1 take data_i[8b+:8]; other bytes are unchanged. wmask_i = 0 makes the write a no-op.
  - way_i >= WAYS: the write is dropped silently.
- RUN, read: when rd_en_i is high, data_o <= all ways at addr_i, one cycle later.
  - When rd_en_i is low, data_o holds its previous value (required by the stalled fetch stage).
- Read and write to the same addr_i in one cycle are write-first: the written way returns the merged new word, other ways return stored contents.
- Read and write to different addresses cannot occur; the interface has a single address.
- rst asserted mid-sweep or mid-operation restarts INIT at cnt = 0. Array contents are then undefined until the sweep completes.
- No back-pressure: ready_o is the only flow control, and callers must not issue accesses while it is low.

Optional Feature:
- Macro: CACHE_DATA_ARRAY_PARITY_EN.
- Defined:
  - Each byte stores an extra even-parity bit, generated on write.
  - On a read, par_err_o[w] is registered alongside data_o and is high if any byte of way w fails the parity check.
  - The INIT sweep writes parity 0, which is consistent with zero data.
  - par_err_o holds its value together with data_o.
- Undefined: no parity storage, and par_err_o is driven to constant 0.

Decomposition:
- Shared package cache_pkg holds:
  - state enum {INIT, RUN};
  - the function computing WAY_W;
  - the byte-parity function;
  - default DATA_W/ADDR_W constants shared with the tag array.
- Sub-module cache_data_bank: one way's DEPTH x DATA_W (+parity) storage with byte-masked write and write-first read. Instantiate it WAYS times from a generate loop; the top level holds the FSM, sweep counter and output register.

Test Plan:
- Reset sweep: pulse rst, ADDR_W=6 -> ready_o low for exactly 64 cycles, high on cycle 65. Then read set 5 -> data_o = 0 for all ways.
- Masked write: write way 1, set 3, data 0xAABBCCDD, mask 4'b1111; then write 0x11223344 with mask 4'b0101. Read set 3 -> way1 = 0xAA22CC44, way0 = 0.
- Write-first collision: rd_en and wr_en together on set 7, way 0, data 0xDEADBEEF, full mask -> data_o way0 = 0xDEADBEEF next cycle.
- Hold: after reading 0xDEADBEEF, hold rd_en low for 5 cycles while writing set 7 -> data_o is unchanged throughout.
- Reset mid-sweep: assert rst at sweep cycle 30 -> ready_o stays low, rises 64 cycles after the second rst deasserts, and accesses issued while ready_o is low are ignored.
- Parity (macro defined): force a stored bit flip in way 0, set 9 via hierarchical deposit; read set 9 -> par_err_o = 2'b01. Read a clean set -> 2'b00.
